// File: rtl/lfsr_gen.sv
// lfsr_gen: WIDTH-bit LFSR with run-time Fibonacci/Galois selection, seed load,
// all-zero lock-up flag and a period meter that counts steps until the state
// returns to its reference value.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (an enabled step from the
// all-zero state reloads SEED instead of staying locked).
// Handshake: there is no valid/ready pair; out is a new registered value every
// cycle, period_done is a one-cycle strobe qualifying period_cnt.
module lfsr_gen #(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] TAPS  = 9'h110,
    parameter logic [WIDTH-1:0] GPOLY = 9'h021,
    parameter logic [WIDTH-1:0] SEED  = 9'h001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             bit_out,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH-1:0] period_cnt
);

`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam logic RECOVER = 1'b1;
`else
    localparam logic RECOVER = 1'b0;
`endif

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] ref_val;   // start value the period is measured against
    logic [WIDTH-1:0] cnt;       // enabled steps since ref_val was last seen
    logic             mode_q;    // registered mode, to detect run-time switches

    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] cnt_inc;
    logic             mode_chg;

    // Next-state candidates for both LFSR forms plus the saturating counter step
    always_comb begin
        fib_next  = {out[WIDTH-2:0], ^(out & TAPS)};
        gal_next  = {out[WIDTH-2:0], 1'b0} ^ ({WIDTH{out[WIDTH-1]}} & GPOLY);
        step_next = mode ? gal_next : fib_next;
        cnt_inc   = (cnt == {WIDTH{1'b1}}) ? cnt : cnt + ONE;
        mode_chg  = (mode != mode_q);
    end

    // Register, reference, period meter; priority rst > load > en > hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out         <= SEED;
            ref_val     <= SEED;
            cnt         <= '0;
            period_cnt  <= '0;
            period_done <= 1'b0;
            mode_q      <= mode;
        end else begin
            mode_q      <= mode;
            period_done <= 1'b0;
            if (load) begin
                out     <= load_val;
                ref_val <= load_val;
                cnt     <= '0;
            end else if (en && RECOVER && (out == '0)) begin
                // Escape the all-zero fixed point by restarting from SEED
                out     <= SEED;
                ref_val <= SEED;
                cnt     <= '0;
            end else if (en) begin
                out <= step_next;
                if (mode_chg) begin
                    // Sequence changed underneath the meter: restart it here
                    ref_val <= out;
                    cnt     <= '0;
                end else if ((out != '0) && (step_next == ref_val)) begin
                    // Zero state is excluded so a locked register never pulses
                    period_done <= 1'b1;
                    period_cnt  <= cnt_inc;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end else if (mode_chg) begin
                ref_val <= out;
                cnt     <= '0;
            end
        end
    end

    assign bit_out = out[WIDTH-1];
    assign lockup  = (out == '0);

endmodule

// File: tb/tb_lfsr_gen.sv
// Testbench for lfsr_gen (default parameters, WIDTH=9).
// The driver pushes the expected post-edge state for every cycle it drives;
// a separate monitor pops one entry after each rising edge and compares.
module tb_lfsr_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       load;
    logic [8:0] load_val;
    logic [8:0] out;
    logic       bit_out;
    logic       lockup;
    logic       period_done;
    logic [8:0] period_cnt;

    typedef struct packed {
        logic [8:0] out;
        logic       done;
        logic [8:0] pcnt;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam logic REC = 1'b1;
`else
    localparam logic REC = 1'b0;
`endif

    localparam logic [8:0] FIB5 [5] = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
    localparam logic [8:0] GAL9 [9] = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h020,
                                        9'h040, 9'h080, 9'h100, 9'h021};

    lfsr_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .load        (load),
        .load_val    (load_val),
        .out         (out),
        .bit_out     (bit_out),
        .lockup      (lockup),
        .period_done (period_done),
        .period_cnt  (period_cnt)
    );

    // Clock and initial input values
    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        load     = 1'b0;
        load_val = '0;
    end
    always #5 clk = ~clk;

    // Reference steps written from the polynomial definitions
    function automatic logic [8:0] fib_m(input logic [8:0] q);
        return {q[7:0], q[8] ^ q[4]};
    endfunction

    function automatic logic [8:0] gal_m(input logic [8:0] q);
        logic [8:0] r;
        r = {q[7:0], 1'b0};
        if (q[8]) r = r ^ 9'h021;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and record what the DUT must show after the edge
    task automatic drive(input logic r, input logic e, input logic m, input logic l,
                         input logic [8:0] lv, input logic [8:0] xo,
                         input logic xd, input logic [8:0] xp);
        exp_t x;
        @(negedge clk);
        rst      = r;
        en       = e;
        mode     = m;
        load     = l;
        load_val = lv;
        x.out    = xo;
        x.done   = xd;
        x.pcnt   = xp;
        exp_q.push_back(x);
    endtask

    // Monitor: compare one expectation after each rising edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("out",         32'(out),         32'(x.out));
                chk("bit_out",     32'(bit_out),     32'(x.out[8]));
                chk("lockup",      32'(lockup),      32'(x.out == 9'h000));
                chk("period_done", 32'(period_done), 32'(x.done));
                chk("period_cnt",  32'(period_cnt),  32'(x.pcnt));
            end
        end
    end

    // Stimulus
    initial begin
        logic [8:0] m;
        int         n;
        logic       e;
        logic       d;
        logic [8:0] p;
        total = 0;
        bad   = 0;

        // Reset state
        drive(1, 0, 0, 0, 9'h000, 9'h001, 0, 9'h000);

        // Fibonacci, five steps from reset
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 9'h000, FIB5[i], 0, 9'h000);

        // Galois, nine steps from reset (mode held high through reset)
        drive(1, 0, 1, 0, 9'h000, 9'h001, 0, 9'h000);
        for (int i = 0; i < 9; i++) drive(0, 1, 1, 0, 9'h000, GAL9[i], 0, 9'h000);

        // Fibonacci free run: pulses after step 511 and 1022
        drive(1, 0, 0, 0, 9'h000, 9'h001, 0, 9'h000);
        m = 9'h001;
        for (int k = 1; k <= 1022; k++) begin
            m = fib_m(m);
            d = (k == 511) || (k == 1022);
            p = (k >= 511) ? 9'd511 : 9'd0;
            drive(0, 1, 0, 0, 9'h000, m, d, p);
        end

        // Enable toggled every other cycle: holds on idle cycles, period unchanged
        drive(1, 0, 0, 0, 9'h000, 9'h001, 0, 9'h000);
        m = 9'h001;
        n = 0;
        for (int i = 0; i < 2044; i++) begin
            e = (i % 2 == 0);
            if (e) begin
                n++;
                m = fib_m(m);
            end
            d = e && ((n == 511) || (n == 1022));
            p = (n >= 511) ? 9'd511 : 9'd0;
            drive(0, e, 0, 0, 9'h000, m, d, p);
        end

        // Load beats enable; period_cnt held across load
        drive(0, 1, 0, 1, 9'h155, 9'h155, 0, 9'd511);
        m = fib_m(9'h155);
        drive(0, 1, 0, 0, 9'h000, m, 0, 9'd511);
        // Run-time switch to Galois: the switching step already uses Galois
        m = gal_m(m);
        drive(0, 1, 1, 0, 9'h000, m, 0, 9'd511);
        m = gal_m(m);
        drive(0, 1, 1, 0, 9'h000, m, 0, 9'd511);

        // Reset beats load
        drive(1, 1, 0, 1, 9'h1ff, 9'h001, 0, 9'h000);

        // Lock-up: load zero, then enabled steps
        drive(0, 1, 0, 1, 9'h000, 9'h000, 0, 9'h000);
        drive(0, 1, 0, 0, 9'h000, REC ? 9'h001 : 9'h000, 0, 9'h000);
        drive(0, 1, 0, 0, 9'h000, REC ? 9'h002 : 9'h000, 0, 9'h000);
        drive(0, 1, 1, 0, 9'h000, REC ? 9'h004 : 9'h000, 0, 9'h000);

        // Let the monitor drain, then report
        drive(0, 0, 1, 0, 9'h000, REC ? 9'h004 : 9'h000, 0, 9'h000);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
